// File: rtl/brick_pkg.sv
// Shared types and constants for the brick hit arbiter.
// Holds the brick-map geometry, the map type indexed [row][col], the
// arbiter FSM state enum and a popcount helper for the live-brick counter.
package brick_pkg;

  localparam int unsigned MATRIX_ROWS = 10;
  localparam int unsigned MATRIX_COLS = 10;
  localparam int unsigned COORD_W     = 11;
  localparam int unsigned COUNT_W     = 7;
  localparam int unsigned SCORE_W     = 8;
  localparam int unsigned CELLS       = MATRIX_ROWS * MATRIX_COLS;

  typedef logic [0:MATRIX_ROWS-1][MATRIX_COLS-1:0] brick_matrix_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    UPDATE = 2'd2
  } arb_state_t;

  // Number of live bricks in a map.
  function automatic logic [COUNT_W-1:0] count_bricks(input brick_matrix_t m);
    logic [CELLS-1:0]   flat;
    logic [COUNT_W-1:0] cnt;
    flat = m;
    cnt  = '0;
    for (int i = 0; i < int'(CELLS); i++) begin
      cnt = cnt + COUNT_W'(flat[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/brick_hit_arbiter_if.sv
// Missile hit request/response bundle.
// master: requester side (drives hitReq, hitX, hitY; sees hitAck, hitValid)
// slave : arbiter side
// With BRICK_HIT_SCORE_EN defined the bundle also carries hitScore
// (per-requester 8-bit saturating score, driven by the arbiter).
interface brick_hit_arbiter_if
  import brick_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
);

  logic [NUM_REQ-1:0]              hitReq;
  logic [NUM_REQ-1:0][COORD_W-1:0] hitX;
  logic [NUM_REQ-1:0][COORD_W-1:0] hitY;
  logic [NUM_REQ-1:0]              hitAck;
  logic [NUM_REQ-1:0]              hitValid;
`ifdef BRICK_HIT_SCORE_EN
  logic [NUM_REQ-1:0][SCORE_W-1:0] hitScore;

  modport master (output hitReq, hitX, hitY, input hitAck, hitValid, hitScore);
  modport slave  (input hitReq, hitX, hitY, output hitAck, hitValid, hitScore);
`else
  modport master (output hitReq, hitX, hitY, input hitAck, hitValid);
  modport slave  (input hitReq, hitX, hitY, output hitAck, hitValid);
`endif

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector.
// req    : request vector
// ptr    : index with highest priority this round
// grant  : index of the first set request at or after ptr (wrapping)
// anyReq : at least one request set
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   grant,
  output logic               anyReq
);

  int unsigned idx;

  // Walk from ptr upward; the first set request wins.
  always_comb begin
    grant  = '0;
    anyReq = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!anyReq && req[IDX_W'(idx)]) begin
        grant  = IDX_W'(idx);
        anyReq = 1'b1;
      end
    end
  end

endmodule

// File: rtl/brick_hit_arbiter.sv
// Brick hit arbiter: serialises missile hit requests onto a 10x10 brick map.
// A round-robin winner is latched in IDLE, its cell is located in CALC and
// the brick is cleared (if present) in UPDATE, giving one hit per 3 cycles.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   bus (slave)       : hitReq/hitX/hitY in, hitAck/hitValid out
//   matrixTopLeftX/Y  : pixel origin of the brick map
//   levelLoad         : reloads INIT_MATRIX and aborts any hit in flight
//   brickMatrix       : live brick map [row][col]
//   bricksLeft        : number of live bricks
//   busy              : FSM not in IDLE
// Optional: BRICK_HIT_SCORE_EN adds per-requester saturating hitScore on bus.
module brick_hit_arbiter
  import brick_pkg::*;
#(
  parameter int unsigned   NUM_REQ      = 2,
  parameter int unsigned   BRICK_WIDTH  = 32,
  parameter int unsigned   BRICK_HEIGHT = 32,
  parameter brick_matrix_t INIT_MATRIX  = '1
) (
  input  logic               clk,
  input  logic               reset,
  brick_hit_arbiter_if.slave bus,
  input  logic [COORD_W-1:0] matrixTopLeftX,
  input  logic [COORD_W-1:0] matrixTopLeftY,
  input  logic               levelLoad,
  output brick_matrix_t      brickMatrix,
  output logic [COUNT_W-1:0] bricksLeft,
  output logic               busy
);

  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned COL_SH = $clog2(BRICK_WIDTH);
  localparam int unsigned ROW_SH = $clog2(BRICK_HEIGHT);
  localparam int unsigned OFS_W  = COORD_W + 1;
  localparam int unsigned CELL_W = 4;
  localparam logic [COUNT_W-1:0] INIT_COUNT = count_bricks(INIT_MATRIX);

  arb_state_t           state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [IDX_W-1:0]     grant;
  logic                 any_req;
  logic [IDX_W-1:0]     winner_q;
  logic [COORD_W-1:0]   x_q, y_q;
  logic [OFS_W-1:0]     dx_c, dy_c, col_c, row_c;
  logic                 in_range_c;
  logic [CELL_W-1:0]    row_q, col_q;
  logic                 in_range_q;
  logic                 brick_hit_c;
  brick_matrix_t        matrix_q;
  logic [COUNT_W-1:0]   left_q;
  logic [NUM_REQ-1:0]   ack_q, valid_q;
  logic                 busy_q;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req    (bus.hitReq),
    .ptr    (rr_ptr_q),
    .grant  (grant),
    .anyReq (any_req)
  );

  // Signed offsets from the map origin; a set MSB means left of / above it.
  assign dx_c       = {1'b0, x_q} - {1'b0, matrixTopLeftX};
  assign dy_c       = {1'b0, y_q} - {1'b0, matrixTopLeftY};
  assign col_c      = dx_c >> COL_SH;
  assign row_c      = dy_c >> ROW_SH;
  assign in_range_c = !dx_c[OFS_W-1] && !dy_c[OFS_W-1] &&
                      (col_c <= OFS_W'(MATRIX_COLS - 1)) &&
                      (row_c <= OFS_W'(MATRIX_ROWS - 1));

  // row_q/col_q are only meaningful when in_range_q is set.
  assign brick_hit_c = in_range_q && matrix_q[row_q][col_q];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state; levelLoad forces IDLE, aborting any hit in flight.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = CALC;
      CALC:    state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (levelLoad) state_d = IDLE;
  end

  // Datapath: latch winner, locate cell, update map and acknowledge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      winner_q   <= '0;
      x_q        <= '0;
      y_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
      in_range_q <= 1'b0;
      matrix_q   <= INIT_MATRIX;
      left_q     <= INIT_COUNT;
      ack_q      <= '0;
      valid_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      busy_q  <= (state_d != IDLE);
      ack_q   <= '0;
      valid_q <= '0;
      if (levelLoad) begin
        matrix_q <= INIT_MATRIX;
        left_q   <= INIT_COUNT;
      end else begin
        case (state_q)
          IDLE: begin
            if (any_req) begin
              winner_q <= grant;
              x_q      <= bus.hitX[grant];
              y_q      <= bus.hitY[grant];
            end
          end
          CALC: begin
            row_q      <= CELL_W'(row_c);
            col_q      <= CELL_W'(col_c);
            in_range_q <= in_range_c;
          end
          UPDATE: begin
            ack_q[winner_q] <= 1'b1;
            rr_ptr_q <= (32'(winner_q) == NUM_REQ - 1) ? '0 : winner_q + IDX_W'(1);
            if (brick_hit_c) begin
              matrix_q[row_q][col_q] <= 1'b0;
              left_q                 <= left_q - COUNT_W'(1);
              valid_q[winner_q]      <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef BRICK_HIT_SCORE_EN
  logic [NUM_REQ-1:0][SCORE_W-1:0] score_q;

  // Saturating per-requester score; survives levelLoad.
  always_ff @(posedge clk) begin
    if (reset) begin
      score_q <= '0;
    end else if (!levelLoad && state_q == UPDATE && brick_hit_c &&
                 score_q[winner_q] != '1) begin
      score_q[winner_q] <= score_q[winner_q] + SCORE_W'(1);
    end
  end

  assign bus.hitScore = score_q;
`endif

  assign bus.hitAck   = ack_q;
  assign bus.hitValid = valid_q;
  assign brickMatrix  = matrix_q;
  assign bricksLeft   = left_q;
  assign busy         = busy_q;

endmodule
